// File: rtl/pwm_pkg.sv
// Shared PWM constants, duty-update encoding and a saturating step helper
// used by the PWM generator and later motor-control blocks.
package pwm_pkg;

    localparam int PWM_PERIOD    = 100;
    localparam int PWM_STEP      = 10;
    localparam int PWM_DUTY_INIT = 50;

    typedef enum logic [1:0] {
        UPD_HOLD,
        UPD_LOAD,
        UPD_INC,
        UPD_DEC
    } duty_upd_e;

    // Works at 32 bits so an increase near the limit can never wrap.
    function automatic int unsigned sat_step(
        input int unsigned value,
        input int unsigned step,
        input int unsigned limit,
        input logic        up
    );
        int unsigned sum;
        sum = value + step;
        if (up) begin
            return (sum > limit) ? limit : sum;
        end
        return (value < step) ? 32'd0 : value - step;
    endfunction

endpackage

// File: rtl/pwm_btn_edge.sv
// Two-flop synchroniser followed by a rising-edge detector for one
// asynchronous button level; a held level yields a single pulse.
module pwm_btn_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic level,
    output logic rise
);

    logic sync1;
    logic sync2;
    logic prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= level;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign rise = sync2 & ~prev;

endmodule

// File: rtl/pwm_multi_gen.sv
// Multi-channel PWM generator sharing one period counter; per-channel duty
// comes from button steps or host loads and is applied only at the wrap.
module pwm_multi_gen
    import pwm_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int CNT_W     = 8,
    parameter int PERIOD    = PWM_PERIOD,
    parameter int STEP      = PWM_STEP,
    parameter int DUTY_INIT = PWM_DUTY_INIT,
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic [NUM_CH-1:0]       increase_duty,
    input  logic [NUM_CH-1:0]       decrease_duty,
    input  logic                    load_en,
    input  logic [CH_W-1:0]         load_ch,
    input  logic [CNT_W-1:0]        load_val,
    output logic [NUM_CH-1:0]       PWM_OUT,
    output logic                    period_start,
    output logic [NUM_CH*CNT_W-1:0] duty_active
);

    localparam logic [CNT_W-1:0] PERIOD_C = CNT_W'(PERIOD);
    localparam logic [CNT_W-1:0] LAST_C   = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] INIT_C   = CNT_W'(DUTY_INIT);

    logic [CNT_W-1:0]  cnt;
    logic              wrap;
    logic [NUM_CH-1:0] inc_rise;
    logic [NUM_CH-1:0] dec_rise;
    logic [CNT_W-1:0]  load_sat;
    logic [CNT_W-1:0]  duty_pending [NUM_CH];
    logic [CNT_W-1:0]  pending_nxt  [NUM_CH];
    logic [CNT_W-1:0]  duty_act     [NUM_CH];
    duty_upd_e         upd          [NUM_CH];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_btn
        pwm_btn_edge u_inc (
            .clk   (clk),
            .rst_n (rst_n),
            .level (increase_duty[i]),
            .rise  (inc_rise[i])
        );
        pwm_btn_edge u_dec (
            .clk   (clk),
            .rst_n (rst_n),
            .level (decrease_duty[i]),
            .rise  (dec_rise[i])
        );
        assign duty_active[i*CNT_W +: CNT_W] = duty_act[i];
    end

    assign wrap     = (cnt == LAST_C);
    assign load_sat = (load_val > PERIOD_C) ? PERIOD_C : load_val;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (wrap) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Host load beats buttons; simultaneous inc and dec cancel out.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            upd[i]         = UPD_HOLD;
            pending_nxt[i] = duty_pending[i];
            if (load_en && (32'(load_ch) == i)) begin
                upd[i] = UPD_LOAD;
            end else if (inc_rise[i] && !dec_rise[i]) begin
                upd[i] = UPD_INC;
            end else if (dec_rise[i] && !inc_rise[i]) begin
                upd[i] = UPD_DEC;
            end
            case (upd[i])
                UPD_LOAD: pending_nxt[i] = load_sat;
                UPD_INC:  pending_nxt[i] = CNT_W'(sat_step(32'(duty_pending[i]), STEP, PERIOD, 1'b1));
                UPD_DEC:  pending_nxt[i] = CNT_W'(sat_step(32'(duty_pending[i]), STEP, PERIOD, 1'b0));
                default:  pending_nxt[i] = duty_pending[i];
            endcase
        end
    end

    // The wrap takes the next-pending value so a same-edge update is not lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                duty_pending[i] <= INIT_C;
                duty_act[i]     <= INIT_C;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                duty_pending[i] <= pending_nxt[i];
                if (wrap) begin
                    duty_act[i] <= pending_nxt[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            PWM_OUT      <= '0;
            period_start <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                PWM_OUT[i] <= enable && (cnt < duty_act[i]);
            end
            period_start <= (cnt == '0);
        end
    end

endmodule

// File: tb/tb_pwm_multi_gen.sv
// Self-checking bench for pwm_multi_gen (2 channels): directed scenarios plus
// a random phase, compared every cycle against a period/duty reference model.
module tb_pwm_multi_gen;

    localparam int NUM_CH    = 2;
    localparam int CNT_W     = 8;
    localparam int PERIOD    = 100;
    localparam int STEP      = 10;
    localparam int DUTY_INIT = 50;

    logic                    clk;
    logic                    rst_n;
    logic                    enable;
    logic [NUM_CH-1:0]       increase_duty;
    logic [NUM_CH-1:0]       decrease_duty;
    logic                    load_en;
    logic [0:0]              load_ch;
    logic [CNT_W-1:0]        load_val;
    logic [NUM_CH-1:0]       PWM_OUT;
    logic                    period_start;
    logic [NUM_CH*CNT_W-1:0] duty_active;

    int total = 0;
    int bad   = 0;

    // Reference model: position in period, requested and applied duty,
    // and the last three sampled button levels (oldest first).
    int         m_cnt;
    int         m_pend [NUM_CH];
    int         m_act  [NUM_CH];
    logic [1:0] m_pwm;
    logic       m_ps;
    logic [1:0] inc_q [$];
    logic [1:0] dec_q [$];

    pwm_multi_gen #(
        .NUM_CH    (NUM_CH),
        .CNT_W     (CNT_W),
        .PERIOD    (PERIOD),
        .STEP      (STEP),
        .DUTY_INIT (DUTY_INIT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .increase_duty (increase_duty),
        .decrease_duty (decrease_duty),
        .load_en       (load_en),
        .load_ch       (load_ch),
        .load_val      (load_val),
        .PWM_OUT       (PWM_OUT),
        .period_start  (period_start),
        .duty_active   (duty_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        m_cnt = 0;
        m_pwm = '0;
        m_ps  = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            m_pend[c] = DUTY_INIT;
            m_act[c]  = DUTY_INIT;
        end
        inc_q = '{2'b00, 2'b00, 2'b00};
        dec_q = '{2'b00, 2'b00, 2'b00};
    endtask

    // A level first sampled at edge k acts as a press at edge k+2.
    task automatic modelEdge();
        logic [1:0] p_inc;
        logic [1:0] p_dec;
        int         p;
        p_inc = inc_q[1] & ~inc_q[0];
        p_dec = dec_q[1] & ~dec_q[0];
        void'(inc_q.pop_front());
        void'(dec_q.pop_front());
        inc_q.push_back(increase_duty);
        dec_q.push_back(decrease_duty);
        for (int c = 0; c < NUM_CH; c++) begin
            m_pwm[c] = enable && (m_cnt < m_act[c]);
        end
        m_ps = (m_cnt == 0);
        for (int c = 0; c < NUM_CH; c++) begin
            p = m_pend[c];
            if (load_en && (int'(load_ch) == c)) begin
                p = (int'(load_val) > PERIOD) ? PERIOD : int'(load_val);
            end else if (p_inc[c] && p_dec[c]) begin
                p = m_pend[c];
            end else if (p_inc[c]) begin
                p = (p + STEP > PERIOD) ? PERIOD : p + STEP;
            end else if (p_dec[c]) begin
                p = (p - STEP < 0) ? 0 : p - STEP;
            end
            m_pend[c] = p;
        end
        if (m_cnt == PERIOD - 1) begin
            for (int c = 0; c < NUM_CH; c++) m_act[c] = m_pend[c];
        end
        m_cnt = (m_cnt + 1) % PERIOD;
    endtask

    task automatic applyStimulus(input logic [1:0] inc, input logic [1:0] dec,
                                 input logic ld_en, input logic ld_ch, input logic [7:0] ld_val);
        increase_duty = inc;
        decrease_duty = dec;
        load_en       = ld_en;
        load_ch       = ld_ch;
        load_val      = ld_val;
        modelEdge();
        @(posedge clk);
        #1;
        checkOutput("pwm_out", 32'(PWM_OUT), 32'(m_pwm));
        checkOutput("period_start", 32'(period_start), 32'(m_ps));
        checkOutput("duty_active", 32'(duty_active), {16'd0, 8'(m_act[1]), 8'(m_act[0])});
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) applyStimulus(2'b00, 2'b00, 1'b0, 1'b0, 8'd0);
    endtask

    task automatic runToCnt(input int target);
        for (int g = 0; g < 2 * PERIOD && m_cnt != target; g++) idle(1);
    endtask

    task automatic press(input logic [1:0] inc, input logic [1:0] dec, input int n, input int width);
        for (int k = 0; k < n; k++) begin
            for (int w = 0; w < width; w++) applyStimulus(inc, dec, 1'b0, 1'b0, 8'd0);
            idle(width);
        end
    endtask

    initial begin
        int sum_pwm;
        int sum_ps;
        logic [1:0] r_inc;
        logic [1:0] r_dec;

        rst_n = 1'b0; enable = 1'b1;
        increase_duty = '0; decrease_duty = '0;
        load_en = 1'b0; load_ch = '0; load_val = '0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_pwm", 32'(PWM_OUT), 32'd0);
        checkOutput("reset_ps", 32'(period_start), 32'd0);
        checkOutput("reset_duty", 32'(duty_active), {16'd0, 8'd50, 8'd50});
        #2 rst_n = 1'b1;

        idle(200);

        runToCnt(10);
        press(2'b01, 2'b00, 3, 10);
        idle(2);
        runToCnt(90);
        checkOutput("duty0_not_yet", 32'(duty_active[7:0]), 32'd50);
        runToCnt(0);
        checkOutput("duty0_80", 32'(duty_active[7:0]), 32'd80);
        checkOutput("duty1_50", 32'(duty_active[15:8]), 32'd50);

        runToCnt(10);
        press(2'b01, 2'b00, 6, 3);
        runToCnt(0);
        checkOutput("duty0_sat100", 32'(duty_active[7:0]), 32'd100);
        sum_pwm = 0;
        for (int k = 0; k < 200; k++) begin idle(1); sum_pwm += int'(PWM_OUT[0]); end
        checkOutput("pwm0_full_high", 32'(sum_pwm), 32'd200);

        runToCnt(10);
        press(2'b00, 2'b01, 11, 3);
        runToCnt(0);
        checkOutput("duty0_zero", 32'(duty_active[7:0]), 32'd0);
        sum_pwm = 0;
        for (int k = 0; k < 200; k++) begin idle(1); sum_pwm += int'(PWM_OUT[0]); end
        checkOutput("pwm0_full_low", 32'(sum_pwm), 32'd0);

        runToCnt(10);
        press(2'b10, 2'b10, 1, 3);
        runToCnt(0);
        checkOutput("duty1_incdec", 32'(duty_active[15:8]), 32'd50);
        runToCnt(10);
        applyStimulus(2'b00, 2'b00, 1'b1, 1'b1, 8'd200);
        runToCnt(0);
        checkOutput("duty1_load_sat", 32'(duty_active[15:8]), 32'd100);

        runToCnt(10);
        applyStimulus(2'b01, 2'b00, 1'b0, 1'b0, 8'd0);
        applyStimulus(2'b01, 2'b00, 1'b0, 1'b0, 8'd0);
        applyStimulus(2'b01, 2'b00, 1'b1, 1'b0, 8'd30);
        idle(4);
        runToCnt(0);
        checkOutput("duty0_load_wins", 32'(duty_active[7:0]), 32'd30);
        runToCnt(PERIOD - 1);
        applyStimulus(2'b00, 2'b00, 1'b1, 1'b0, 8'd70);
        checkOutput("duty0_wrap_load", 32'(duty_active[7:0]), 32'd70);

        runToCnt(37);
        checkOutput("pwm1_high_pre_reset", 32'(PWM_OUT[1]), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_pwm", 32'(PWM_OUT), 32'd0);
        checkOutput("async_reset_duty", 32'(duty_active), {16'd0, 8'd50, 8'd50});
        modelReset();
        #3 rst_n = 1'b1;
        idle(1);
        checkOutput("restart_ps", 32'(period_start), 32'd1);
        idle(150);

        enable = 1'b0;
        sum_pwm = 0;
        sum_ps  = 0;
        for (int k = 0; k < 200; k++) begin
            idle(1);
            sum_pwm += int'(PWM_OUT[0]) + int'(PWM_OUT[1]);
            sum_ps  += int'(period_start);
        end
        checkOutput("disabled_pwm", 32'(sum_pwm), 32'd0);
        checkOutput("disabled_ps_count", 32'(sum_ps), 32'd2);

        enable = 1'b1;
        r_inc = '0;
        r_dec = '0;
        for (int k = 0; k < 600; k++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if ($urandom_range(0, 7) == 0) r_inc[c] = ~r_inc[c];
                if ($urandom_range(0, 7) == 0) r_dec[c] = ~r_dec[c];
            end
            if ($urandom_range(0, 49) == 0) enable = ~enable;
            applyStimulus(r_inc, r_dec, ($urandom_range(0, 19) == 0),
                          1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
        end
        idle(PERIOD + 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
